// File: rtl/rgmii_tx_frame_arb_if.sv
// rgmii_tx_frame_arb_if: byte-stream handshake bundle for the two frame sources and the transmitter side
interface rgmii_tx_frame_arb_if;
  logic [7:0] s0_tdata;
  logic       s0_tvalid;
  logic       s0_tlast;
  logic       s0_tready;
  logic [7:0] s1_tdata;
  logic       s1_tvalid;
  logic       s1_tlast;
  logic       s1_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;
  modport slave (
    input  s0_tdata, s0_tvalid, s0_tlast, s1_tdata, s1_tvalid, s1_tlast, m_tready,
    output s0_tready, s1_tready, m_tdata, m_tvalid
  );
  modport master (
    output s0_tdata, s0_tvalid, s0_tlast, s1_tdata, s1_tvalid, s1_tlast, m_tready,
    input  s0_tready, s1_tready, m_tdata, m_tvalid
  );
endinterface

// File: rtl/rgmii_tx_frame_arb.sv
// rgmii_tx_frame_arb: round-robin frame scheduler adding preamble/SFD and speed-scaled inter-frame gap
module rgmii_tx_frame_arb #(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_BYTES    = 12
) (
  input  logic                      clk_125mhz,
  input  logic                      reset,
  input  logic                      phy_link_status,
  input  logic [1:0]                phy_speed_status,
  rgmii_tx_frame_arb_if.slave       bus,
  output logic [1:0]                grant,
  output logic [1:0]                frame_done,
  output logic                      underrun_err
);
  typedef enum logic [2:0] {IDLE, PRE, DATA, IFG, DRAIN} state_t;
  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [2:0]  pre_cnt_q, pre_cnt_d;
  logic [10:0] ifg_cnt_q, ifg_cnt_d;
  logic [10:0] ifg_lim_q, ifg_lim_d;
  logic [10:0] lim_new;
  logic [7:0]  sel_data, m_data;
  logic        sel_valid, sel_last, sfd, m_valid, s_rdy, done, underrun, to_ifg;
  assign sel_data  = owner_q ? bus.s1_tdata  : bus.s0_tdata;
  assign sel_valid = owner_q ? bus.s1_tvalid : bus.s0_tvalid;
  assign sel_last  = owner_q ? bus.s1_tlast  : bus.s0_tlast;
  assign sfd       = pre_cnt_q == 3'(PREAMBLE_LEN);
  assign lim_new   = (phy_speed_status == 2'd0) ? 11'(IFG_BYTES * 100 - 1) :
                     (phy_speed_status == 2'd1) ? 11'(IFG_BYTES * 10 - 1) : 11'(IFG_BYTES - 1);
  // next-state and output decode; a dropped link in DATA already discards bytes in that same cycle
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    pre_cnt_d = pre_cnt_q;
    ifg_cnt_d = ifg_cnt_q;
    ifg_lim_d = ifg_lim_q;
    m_valid   = 1'b0;
    m_data    = 8'h00;
    s_rdy     = 1'b0;
    done      = 1'b0;
    underrun  = 1'b0;
    to_ifg    = 1'b0;
    case (state_q)
      IDLE: if (phy_link_status && (bus.s0_tvalid || bus.s1_tvalid)) begin
        owner_d   = (bus.s0_tvalid && bus.s1_tvalid) ? ~last_q : bus.s1_tvalid;
        pre_cnt_d = 3'd0;
        state_d   = PRE;
      end
      PRE: begin
        m_valid = 1'b1;
        m_data  = sfd ? 8'hD5 : 8'h55;
        if (!phy_link_status) to_ifg = 1'b1;
        else if (bus.m_tready) begin
          pre_cnt_d = pre_cnt_q + 3'd1;
          if (sfd) state_d = DATA;
        end
      end
      DATA: begin
        m_valid  = phy_link_status & sel_valid;
        m_data   = sel_data;
        s_rdy    = phy_link_status ? bus.m_tready : 1'b1;
        underrun = phy_link_status & bus.m_tready & ~sel_valid;
        if (s_rdy && sel_valid && sel_last) begin
          done   = 1'b1;
          to_ifg = 1'b1;
        end else if (!phy_link_status) state_d = DRAIN;
      end
      DRAIN: begin
        s_rdy = 1'b1;
        if (sel_valid && sel_last) begin
          done   = 1'b1;
          to_ifg = 1'b1;
        end
      end
      IFG: begin
        ifg_cnt_d = ifg_cnt_q + 11'd1;
        if (ifg_cnt_q == ifg_lim_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (done) last_d = owner_q;
    if (to_ifg) begin
      state_d   = IFG;
      ifg_cnt_d = 11'd0;
      ifg_lim_d = lim_new;
    end
  end
  // state registers; last_served starts at port 1 so port 0 wins the first tie
  always_ff @(posedge clk_125mhz) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      pre_cnt_q <= 3'd0;
      ifg_cnt_q <= 11'd0;
      ifg_lim_q <= 11'd0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      pre_cnt_q <= pre_cnt_d;
      ifg_cnt_q <= ifg_cnt_d;
      ifg_lim_q <= ifg_lim_d;
    end
  end
  assign bus.m_tvalid  = m_valid;
  assign bus.m_tdata   = m_data;
  assign bus.s0_tready = s_rdy & ~owner_q;
  assign bus.s1_tready = s_rdy & owner_q;
  assign grant         = (state_q == PRE || state_q == DATA || state_q == DRAIN) ? {owner_q, ~owner_q} : 2'b00;
  assign frame_done    = done ? {owner_q, ~owner_q} : 2'b00;
  assign underrun_err  = underrun;
endmodule

// File: tb/tb_rgmii_tx_frame_arb.sv
// tb_rgmii_tx_frame_arb: scoreboard bench with a frame-level round-robin reference model
module tb_rgmii_tx_frame_arb;
  localparam int PRE_N = 7;
  localparam int IFG_N = 12;
  logic       clk_125mhz = 1'b0;
  logic       reset, phy_link_status;
  logic [1:0] phy_speed_status;
  logic [1:0] grant, frame_done;
  logic       underrun_err;
  rgmii_tx_frame_arb_if bus();
  rgmii_tx_frame_arb dut (
    .clk_125mhz(clk_125mhz), .reset(reset), .phy_link_status(phy_link_status),
    .phy_speed_status(phy_speed_status), .bus(bus), .grant(grant),
    .frame_done(frame_done), .underrun_err(underrun_err)
  );
  initial forever #4 clk_125mhz = ~clk_125mhz;

  logic [8:0] sq0[$], sq1[$], f0[$], f1[$];
  logic [9:0] exp_q[$];
  bit         done_q[$];
  int errors = 0, checks = 0, cyc = 0, t_done = 0, exp_gap = 14, data_cnt = 0, und_cnt = 0, link_bad = 0;
  bit armed = 0, hold0 = 0, rnd_rdy = 0, m_last = 1;
  logic [1:0] hs = 2'b00, prev_grant = 2'b00;

  function automatic logic [1:0] onehot(bit p);
    return p ? 2'b10 : 2'b01;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic drive();
    bus.s0_tvalid = !hold0 && sq0.size() > 0;
    bus.s0_tdata  = sq0.size() > 0 ? sq0[0][7:0] : 8'h00;
    bus.s0_tlast  = sq0.size() > 0 ? sq0[0][8] : 1'b0;
    bus.s1_tvalid = sq1.size() > 0;
    bus.s1_tdata  = sq1.size() > 0 ? sq1[0][7:0] : 8'h00;
    bus.s1_tlast  = sq1.size() > 0 ? sq1[0][8] : 1'b0;
    bus.m_tready  = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic tick();
    @(posedge clk_125mhz);
    #1;
    if (hs[0] && sq0.size() > 0) sq0.delete(0);
    if (hs[1] && sq1.size() > 0) sq1.delete(0);
    drive();
  endtask

  // reference model: whole frames are scheduled round-robin, each prefixed by preamble and SFD
  task automatic load();
    logic [8:0] a[$], b[$], w;
    bit p;
    a = f0;
    b = f1;
    while (a.size() > 0 || b.size() > 0) begin
      p = (a.size() > 0 && b.size() > 0) ? !m_last : (b.size() > 0);
      for (int i = 0; i <= PRE_N; i++) exp_q.push_back({p, 1'b0, (i == PRE_N) ? 8'hD5 : 8'h55});
      do begin
        if (p) w = b.pop_front(); else w = a.pop_front();
        exp_q.push_back({p, 1'b1, w[7:0]});
      end while (!w[8]);
      done_q.push_back(p);
      m_last = p;
    end
    foreach (f0[i]) sq0.push_back(f0[i]);
    foreach (f1[i]) sq1.push_back(f1[i]);
    f0.delete();
    f1.delete();
  endtask

  task automatic add(bit p, int len);
    logic [8:0] v;
    for (int i = 0; i < len; i++) begin
      v = {i == len - 1, 8'($urandom)};
      if (p) f1.push_back(v); else f0.push_back(v);
    end
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    while ((exp_q.size() > 0 || done_q.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    chk("scoreboard_drained_in_time", n < budget, 1);
  endtask

  task automatic wait_data(int want);
    int n = 0;
    while (data_cnt < want && n < 500) begin
      tick();
      n++;
    end
    chk("data_bytes_reached", data_cnt >= want, 1);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    sq0.delete();
    sq1.delete();
    exp_q.delete();
    done_q.delete();
    m_last = 1;
    armed = 0;
    drive();
    tick();
    tick();
    reset = 1'b0;
    data_cnt = 0;
  endtask

  // monitor: pops expected bytes on every transmitter handshake, checks frame ends and gap lengths
  initial forever begin
    @(negedge clk_125mhz);
    cyc++;
    hs = {bus.s1_tvalid & bus.s1_tready, bus.s0_tvalid & bus.s0_tready};
    if (!reset) begin
      if (bus.m_tvalid && !phy_link_status) link_bad++;
      if (underrun_err) und_cnt++;
      if (bus.m_tvalid && bus.m_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h want none (cycle %0d)", bus.m_tdata, cyc);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          chk("grant_and_byte", {grant, bus.m_tdata}, {onehot(e[9]), e[7:0]});
          if (e[8]) data_cnt++;
        end
      end
      if (frame_done != 2'b00) begin
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame_done: got %0h want 0 (cycle %0d)", frame_done, cyc);
        end else chk("frame_done", frame_done, onehot(done_q.pop_front()));
        data_cnt = 0;
        t_done = cyc;
        armed = exp_q.size() > 0;
      end
      if (grant != 2'b00 && prev_grant == 2'b00 && armed) begin
        chk("ifg_gap_cycles", cyc - t_done, exp_gap);
        armed = 0;
      end
    end
    prev_grant = grant;
  end

  initial begin
    reset = 1'b1;
    phy_link_status = 1'b1;
    phy_speed_status = 2'd2;
    drive();
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk_125mhz);
    chk("reset_grant", grant, 0);
    chk("reset_m_tvalid", bus.m_tvalid, 0);
    chk("reset_s_tready", {bus.s1_tready, bus.s0_tready}, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_underrun", underrun_err, 0);

    f0 = {9'h001, 9'h002, 9'h003, 9'h104};
    load();
    wait_done(200);

    apply_reset();
    f0 = {9'h011, 9'h112, 9'h013, 9'h114};
    f1 = {9'h021, 9'h122, 9'h023, 9'h124};
    load();
    wait_done(400);

    rnd_rdy = 1;
    repeat (10) add(1'($urandom_range(0, 1)), $urandom_range(1, 8));
    load();
    wait_done(3000);
    rnd_rdy = 0;

    phy_speed_status = 2'd1;
    exp_gap = IFG_N * 10 + 2;
    add(0, 3);
    add(1, 2);
    load();
    wait_done(1000);

    phy_speed_status = 2'd0;
    exp_gap = IFG_N * 100 + 2;
    add(0, 2);
    add(1, 2);
    load();
    wait_done(4000);

    phy_speed_status = 2'd3;
    exp_gap = IFG_N + 2;
    add(1, 1);
    add(0, 1);
    add(1, 2);
    load();
    wait_done(3000);

    phy_speed_status = 2'd2;
    add(0, 6);
    load();
    repeat (4) exp_q.delete(exp_q.size() - 1);
    wait_data(2);
    phy_link_status = 1'b0;
    wait_done(300);
    chk("drained_source_bytes_left", sq0.size(), 0);
    repeat (5) tick();
    phy_link_status = 1'b1;

    add(0, 4);
    load();
    wait_data(1);
    hold0 = 1;
    drive();
    repeat (3) tick();
    hold0 = 0;
    drive();
    wait_done(300);

    add(0, 6);
    load();
    wait_data(2);
    reset = 1'b1;
    sq0.delete();
    exp_q.delete();
    done_q.delete();
    m_last = 1;
    armed = 0;
    drive();
    tick();
    reset = 1'b0;
    data_cnt = 0;
    @(negedge clk_125mhz);
    chk("post_reset_grant", grant, 0);
    chk("post_reset_m_tvalid", bus.m_tvalid, 0);
    chk("post_reset_s_tready", {bus.s1_tready, bus.s0_tready}, 0);
    add(0, 3);
    load();
    wait_done(300);

    repeat (20) tick();
    chk("underrun_pulses", und_cnt, 3);
    chk("m_tvalid_while_link_down", link_bad, 0);
    chk("scoreboard_leftover", exp_q.size() + done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
